// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  localparam int unsigned PC_W        = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 64'h0;
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR     = 32'h0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch entries with synchronous clear and head peek.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     wdata,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Overflow and underflow requests are ignored rather than corrupting state.
  always_comb begin
    do_push = push & (count != CNT_W'(DEPTH));
    do_pop  = pop & (count != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, in-order imem request/response handling,
// fetch buffer feeding IF/ID, and branch-redirect squashing.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    PC_Out,
  output logic [INSTR_W-1:0] Instruction,
  output logic               fetch_valid,
  output logic               flush
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] drop_d;
  logic [CNT_W-1:0] tag_cnt;
  logic [CNT_W-1:0] buf_cnt;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] credits_used;
  logic             issue;
  logic             rsp_drop;
  logic             rsp_keep;
  logic             pop;
  fetch_entry_t     tag_wdata;
  fetch_entry_t     tag_head;
  fetch_entry_t     buf_wdata;
  fetch_entry_t     buf_head;

  // Every granted request is either tagged (live) or counted for discard,
  // so the outstanding total is their sum. A pop this cycle frees a credit.
  always_comb begin
    outstanding  = tag_cnt + drop_q;
    fetch_valid  = (buf_cnt != '0);
    pop          = fetch_valid & ~stall & ~redirect;
    credits_used = outstanding + buf_cnt - CNT_W'(pop);
    imem_req     = reset & ~redirect & (credits_used < CNT_W'(DEPTH));
    issue        = imem_req & imem_gnt;
    rsp_drop     = imem_rvalid & (drop_q != '0);
    rsp_keep     = imem_rvalid & ~rsp_drop & ~redirect;
    drop_d       = drop_q;
    if (redirect) drop_d = outstanding - CNT_W'(imem_rvalid);
    else if (rsp_drop) drop_d = drop_q - CNT_W'(1);
  end

  always_comb begin
    tag_wdata       = '{pc: pc_q, instr: BUBBLE_INSTR};
    buf_wdata       = tag_head;
    buf_wdata.instr = imem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
      if (redirect) pc_q <= redirect_pc;
      else if (issue) pc_q <= pc_q + PC_W'(INSTR_BYTES);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (issue),
    .wdata (tag_wdata),
    .pop   (rsp_keep),
    .head  (tag_head),
    .count (tag_cnt)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (rsp_keep),
    .wdata (buf_wdata),
    .pop   (pop),
    .head  (buf_head),
    .count (buf_cnt)
  );

  assign imem_addr   = pc_q;
  assign flush       = redirect;
  assign PC_Out      = fetch_valid ? buf_head.pc : '0;
  assign Instruction = fetch_valid ? buf_head.instr : BUBBLE_INSTR;

endmodule
